// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB first, parity, stop; one bit per bit_en strobe.
// Define SERIAL_PARITY_RX_ERR_CNT_EN to build the saturating error counter; otherwise err_cnt is tied to 0.
module serial_parity_rx #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdi,
  input  logic              bit_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic PAR_ODD = (ODD_PARITY != 0);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              acc_reg;
  logic              mismatch_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] data_out_reg;
  logic              data_valid_reg;
  logic              parity_err_reg;
  logic              frame_err_reg;
  logic              stop_ok;
  logic              stop_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    if (bit_en) begin
      case (state_reg)
        IDLE:   if (!sdi) state_next = DATA;
        DATA:   if (cnt_reg == LAST_CNT) state_next = PARITY;
        PARITY: state_next = STOP;
        STOP: begin
          state_next = IDLE;
          stop_ok    = sdi;
          stop_bad   = !sdi;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      acc_reg        <= 1'b0;
      mismatch_reg   <= 1'b0;
      shift_reg      <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      data_valid_reg <= stop_ok;
      frame_err_reg  <= stop_bad;
      if (bit_en) begin
        case (state_reg)
          IDLE: begin
            if (!sdi) begin
              cnt_reg <= '0;
              acc_reg <= 1'b0;
            end
          end
          DATA: begin
            shift_reg[cnt_reg] <= sdi;
            acc_reg            <= acc_reg ^ sdi;
            cnt_reg            <= cnt_reg + CNT_W'(1);
          end
          PARITY: mismatch_reg <= acc_reg ^ sdi ^ PAR_ODD;
          STOP: begin
            // A bad stop bit leaves the previously delivered word and its parity flag intact.
            if (sdi) begin
              data_out_reg   <= shift_reg;
              parity_err_reg <= mismatch_reg;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = (state_reg != IDLE);

`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
  logic [7:0] err_cnt_reg;

  // One count per faulty frame, even when both parity and stop bit are wrong.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= 8'd0;
    end else if (((stop_ok && mismatch_reg) || stop_bad) && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign err_cnt = err_cnt_reg;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx (DATA_W=8, even parity); err_cnt expectations
// follow whether SERIAL_PARITY_RX_ERR_CNT_EN is defined for the build.
module tb_serial_parity_rx;

`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
  localparam bit HAS_CNT = 1'b1;
`else
  localparam bit HAS_CNT = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       sdi;
  logic       bit_en;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  int         dv_count = 0;
  int         fe_count = 0;
  logic [7:0] dv_last = 8'h00;
  logic [7:0] dv_prev = 8'h00;
  int         dv_cyc_last = 0;
  int         dv_cyc_prev = 0;

  serial_parity_rx #(.DATA_W(8), .ODD_PARITY(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sdi        (sdi),
    .bit_en     (bit_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulses are counted on the falling edge so each high cycle is seen exactly once.
  always @(negedge clk) begin
    if (data_valid) begin
      dv_count    <= dv_count + 1;
      dv_prev     <= dv_last;
      dv_last     <= data_out;
      dv_cyc_prev <= dv_cyc_last;
      dv_cyc_last <= cyc;
    end
    if (frame_err) fe_count <= fe_count + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end else begin
      $display("check %s: got 0x%0h", tag, got);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    return HAS_CNT ? 32'(n) : 32'd0;
  endfunction

  // Entered on a falling edge; strobes one bit, then idles gap cycles.
  task automatic send_bit(input logic b, input int gap);
    sdi    = b;
    bit_en = 1'b1;
    @(negedge clk);
    bit_en = 1'b0;
    sdi    = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int gap);
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(d[i], gap);
    send_bit(par, gap);
    send_bit(stp, gap);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  int dv0;
  int fe0;

  initial begin
    rst_n  = 1'b0;
    sdi    = 1'b1;
    bit_en = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_data_out", 32'(data_out), 32'h00);
    check_val("rst_valid", 32'(data_valid), 32'h0);
    check_val("rst_parity_err", 32'(parity_err), 32'h0);
    check_val("rst_frame_err", 32'(frame_err), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_err_cnt", 32'(err_cnt), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Idle line with strobes must not start a frame
    send_bit(1'b1, 0);
    send_bit(1'b1, 1);
    check_val("idle_busy", 32'(busy), 32'h0);

    // Good 0xA5, even parity bit 0
    dv0 = dv_count;
    send_bit(1'b0, 0);
    check_val("start_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 8; i++) send_bit(1'(8'hA5 >> i), 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    settle();
    check_val("a5_pulses", 32'(dv_count - dv0), 32'd1);
    check_val("a5_data", 32'(data_out), 32'hA5);
    check_val("a5_parity_err", 32'(parity_err), 32'h0);
    check_val("a5_busy", 32'(busy), 32'h0);

    // 0xA5 with wrong parity bit
    dv0 = dv_count;
    send_frame(8'hA5, 1'b1, 1'b1, 1);
    settle();
    check_val("a5bad_pulses", 32'(dv_count - dv0), 32'd1);
    check_val("a5bad_data", 32'(data_out), 32'hA5);
    check_val("a5bad_parity_err", 32'(parity_err), 32'h1);
    check_val("a5bad_err_cnt", 32'(err_cnt), exp_cnt(1));

    // 0x3C with bad stop bit
    dv0 = dv_count;
    fe0 = fe_count;
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    settle();
    check_val("3c_frame_err_pulses", 32'(fe_count - fe0), 32'd1);
    check_val("3c_valid_pulses", 32'(dv_count - dv0), 32'd0);
    check_val("3c_data_kept", 32'(data_out), 32'hA5);
    check_val("3c_parity_err_kept", 32'(parity_err), 32'h1);
    check_val("3c_err_cnt", 32'(err_cnt), exp_cnt(2));

    // Back-to-back 0x01 then 0xFF, bit_en every cycle
    dv0 = dv_count;
    send_frame(8'h01, 1'b1, 1'b1, 0);
    send_frame(8'hFF, 1'b0, 1'b1, 0);
    settle();
    check_val("b2b_pulses", 32'(dv_count - dv0), 32'd2);
    check_val("b2b_first", 32'(dv_prev), 32'h01);
    check_val("b2b_second", 32'(dv_last), 32'hFF);
    check_val("b2b_spacing", 32'(dv_cyc_last - dv_cyc_prev), 32'd11);
    check_val("b2b_parity_err", 32'(parity_err), 32'h0);

    // Reset after 4 data bits, bit_en every 3rd cycle
    dv0 = dv_count;
    fe0 = fe_count;
    send_bit(1'b0, 2);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 2);
    check_val("abort_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check_val("abort_busy_in_reset", 32'(busy), 32'h0);
    check_val("abort_data_in_reset", 32'(data_out), 32'h00);
    check_val("abort_err_cnt_in_reset", 32'(err_cnt), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) send_bit(1'b1, 2);
    check_val("abort_no_valid", 32'(dv_count - dv0), 32'd0);
    check_val("abort_no_frame_err", 32'(fe_count - fe0), 32'd0);
    check_val("abort_busy_after", 32'(busy), 32'h0);
    send_frame(8'h5A, 1'b0, 1'b1, 2);
    settle();
    check_val("5a_pulses", 32'(dv_count - dv0), 32'd1);
    check_val("5a_data", 32'(data_out), 32'h5A);
    check_val("5a_parity_err", 32'(parity_err), 32'h0);

    // Bad parity and bad stop in one frame: one error count
    dv0 = dv_count;
    fe0 = fe_count;
    send_frame(8'h81, 1'b1, 1'b0, 0);
    settle();
    check_val("both_frame_err", 32'(fe_count - fe0), 32'd1);
    check_val("both_no_valid", 32'(dv_count - dv0), 32'd0);
    check_val("both_data_kept", 32'(data_out), 32'h5A);
    check_val("both_err_cnt", 32'(err_cnt), exp_cnt(1));

    // 300 bad-parity frames saturate the counter
    dv0 = dv_count;
    for (int n = 0; n < 300; n++) send_frame(8'h00, 1'b1, 1'b1, 0);
    settle();
    check_val("sat_pulses", 32'(dv_count - dv0), 32'd300);
    check_val("sat_parity_err", 32'(parity_err), 32'h1);
    check_val("sat_err_cnt", 32'(err_cnt), exp_cnt(255));
    send_frame(8'h00, 1'b1, 1'b1, 0);
    settle();
    check_val("sat_err_cnt_hold", 32'(err_cnt), exp_cnt(255));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_parity_rx.md
SERIAL_PARITY_RX -- requirements
Module: serial_parity_rx

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame (legal range 1..16).
REQ-002 Parameter ODD_PARITY, default 0; 0 = even parity, 1 = odd parity.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 sdi  input  1  serial data line; idle level 1.
REQ-006 bit_en  input  1  bit strobe; sdi is sampled only on edges where bit_en=1.
REQ-007 data_out  output  DATA_W  last received data word.
REQ-008 data_valid  output  1  one-cycle pulse marking a completed, well-framed word.
REQ-009 parity_err  output  1  parity mismatch flag for the word flagged by data_valid.
REQ-010 frame_err  output  1  one-cycle pulse; stop bit sampled as 0.
REQ-011 busy  output  1  high while a frame is in progress (state not IDLE).
REQ-012 err_cnt  output  8  error counter; see Configuration.

Function
REQ-013 Frame format, one bit per bit_en: start(0), DATA_W data bits LSB first, parity bit, stop(1).
REQ-014 The FSM SHALL have the states IDLE, DATA, PARITY and STOP, and SHALL advance only on edges where bit_en=1.
REQ-015 IDLE: bit_en with sdi=0 -> DATA, bit counter cleared, parity accumulator cleared; bit_en with sdi=1 -> stay in IDLE.
REQ-016 DATA: each bit_en shifts sdi into bit position = counter and XORs it into the accumulator; after DATA_W bits -> PARITY.
REQ-017 PARITY: on bit_en, store mismatch = accumulator XOR sdi XOR ODD_PARITY; -> STOP.
REQ-018 STOP, bit_en, sdi=1: data_out <= shift register, parity_err <= mismatch, data_valid=1 for exactly the next cycle; -> IDLE.
REQ-019 STOP, bit_en, sdi=0: frame_err=1 for exactly the next cycle, data_valid stays 0, data_out and parity_err unchanged; -> IDLE.
REQ-020 Latency: data_valid/frame_err go high on the same edge that samples the stop bit.
REQ-021 bit_en low for any number of cycles SHALL freeze state, counter, accumulator and shift register.
REQ-022 Back-to-back frames: a start bit on the bit_en immediately after the stop bit SHALL be accepted with no gap.
REQ-023 parity_err holds its value until the next good-stop frame completes.
REQ-024 busy=1 in DATA, PARITY and STOP; busy=0 in IDLE.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE and set data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, err_cnt=0.
REQ-026 Reset mid-frame SHALL discard the partial frame; no data_valid or frame_err pulse SHALL result from it.
REQ-027 After rst_n rises, the first frame SHALL be received normally starting at the next start bit.

Configuration
REQ-028 Macro SERIAL_PARITY_RX_ERR_CNT_EN defined: err_cnt increments by 1 per completed frame with parity_err=1 or frame_err=1, saturating at 255.
REQ-029 If a single frame has both a parity mismatch and a bad stop bit, err_cnt SHALL increment by exactly 1.
REQ-030 Macro undefined: err_cnt SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-031 Even parity, frame 0xA5 with parity bit 0 and stop bit 1 -> data_out=0xA5, one data_valid pulse, parity_err=0.
REQ-032 Frame 0xA5 with parity bit 1 -> data_out=0xA5, data_valid pulse, parity_err=1; with the macro defined, err_cnt=1.
REQ-033 Frame 0x3C with stop bit 0 -> frame_err pulse, no data_valid, data_out keeps its previous value.
REQ-034 Back-to-back frames 0x01 then 0xFF, bit_en every cycle -> two data_valid pulses 11 cycles apart, with data_out 0x01 then 0xFF.
REQ-035 bit_en asserted every 3rd cycle, rst_n pulsed after 4 data bits, then frame 0x5A -> busy=0 during reset, no pulse from the aborted frame, data_out=0x5A.
REQ-036 Macro defined, 300 bad-parity frames -> err_cnt=255 and holds.
